// File: rtl/powlib_epipe.sv
// powlib_epipe: elastic, bubble-collapsing valid/ready pipeline.
// S register stages advance independently, so an empty stage always accepts
// even while later stages are stalled. An optional 2-entry skid buffer in
// front of stage 0 makes in_rdy a flop output. Flush synchronously empties
// every stage and the skid buffer. cnt tracks the number of words held.
module powlib_epipe #(
  parameter int             W     = 8,
  parameter logic [W-1:0]   INIT  = {W{1'b0}},
  parameter int             S     = 4,
  parameter int             ESKID = 0,
  localparam int            CW    = $clog2(S + 3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  // stage state
  logic [S-1:0]  r_v;
  logic [W-1:0]  r_d [S];
  logic [CW-1:0] r_cnt;

  // combinational helpers
  logic [S:0]    w_adv;
  logic [S-1:0]  w_prev_v;
  logic [W-1:0]  w_prev_d [S];
  logic          w_in_rdy;
  logic          w_acc;
  logic          w_emit;
  logic          w_s0_v;
  logic [W-1:0]  w_s0_d;

  assign w_acc    = in_vld & w_in_rdy;
  assign out_vld  = r_v[S-1] & ~flush;
  assign out_data = r_d[S-1];
  assign w_emit   = out_vld & out_rdy;
  assign in_rdy   = w_in_rdy;
  assign cnt      = r_cnt;

  // advance enables: a stage moves when it is empty or the stage after it moves
  always_comb begin
    w_adv    = {(S + 1){1'b0}};
    w_adv[S] = out_rdy;
    for (int i = S - 1; i >= 0; i--) begin
      w_adv[i] = ~r_v[i] | w_adv[i + 1];
    end
  end

  // what each stage would load on an advance: the previous stage or the pipe input
  always_comb begin
    w_prev_v[0] = w_s0_v;
    w_prev_d[0] = w_s0_d;
    for (int i = 1; i < S; i++) begin
      w_prev_v[i] = r_v[i - 1];
      w_prev_d[i] = r_d[i - 1];
    end
  end

  // stage registers; data is only loaded under a valid word so bubbles do not toggle it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= {S{1'b0}};
      for (int i = 0; i < S; i++) begin
        r_d[i] <= INIT;
      end
    end else if (flush) begin
      r_v <= {S{1'b0}};
      for (int i = 0; i < S; i++) begin
        r_d[i] <= INIT;
      end
    end else begin
      for (int i = 0; i < S; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= w_prev_v[i];
          if (w_prev_v[i]) begin
            r_d[i] <= w_prev_d[i];
          end
        end
      end
    end
  end

  // occupancy counter: words accepted minus words emitted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (flush) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(CW - 1){1'b0}}, w_acc} - {{(CW - 1){1'b0}}, w_emit};
    end
  end

  generate
    if (ESKID == 0) begin : g_noskid
      // input ready follows the stage-0 advance enable directly
      assign w_in_rdy = rst & ~flush & w_adv[0];
      assign w_s0_v   = w_acc;
      assign w_s0_d   = in_data;
    end else begin : g_skid
      logic [W-1:0] r_sk_d [2];
      logic [1:0]   r_sk_n;
      logic         r_rdy;
      logic         w_pop;
      logic [1:0]   w_sk_n_nxt;

      // ready comes from a flop so out_rdy never reaches in_rdy combinationally
      assign w_in_rdy = rst & ~flush & r_rdy;
      assign w_s0_v   = (r_sk_n != 2'd0);
      assign w_s0_d   = r_sk_d[0];
      assign w_pop    = w_s0_v & w_adv[0];

      // next skid occupancy from push/pop
      always_comb begin
        w_sk_n_nxt = r_sk_n;
        case ({w_acc, w_pop})
          2'b10:   w_sk_n_nxt = r_sk_n + 2'd1;
          2'b01:   w_sk_n_nxt = r_sk_n - 2'd1;
          default: w_sk_n_nxt = r_sk_n;
        endcase
      end

      // skid storage: entry 0 is always the oldest word
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sk_n    <= 2'd0;
          r_rdy     <= 1'b0;
          r_sk_d[0] <= INIT;
          r_sk_d[1] <= INIT;
        end else if (flush) begin
          r_sk_n    <= 2'd0;
          r_rdy     <= 1'b1;
          r_sk_d[0] <= INIT;
          r_sk_d[1] <= INIT;
        end else begin
          r_sk_n <= w_sk_n_nxt;
          r_rdy  <= (w_sk_n_nxt < 2'd2);
          case ({w_acc, w_pop})
            2'b10: begin
              if (r_sk_n == 2'd0) begin
                r_sk_d[0] <= in_data;
              end else begin
                r_sk_d[1] <= in_data;
              end
            end
            2'b01: begin
              if (r_sk_n == 2'd2) begin
                r_sk_d[0] <= r_sk_d[1];
              end
            end
            2'b11: begin
              if (r_sk_n == 2'd1) begin
                r_sk_d[0] <= in_data;
              end else begin
                r_sk_d[0] <= r_sk_d[1];
                r_sk_d[1] <= in_data;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_powlib_epipe.sv
// Bench for powlib_epipe: one instance without skid (directed + random) and
// one with skid (random). A word/position model predicts every output cycle.
module tb_powlib_epipe;
  localparam int S = 4;
  localparam logic [7:0] INIT = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       i_vld   [2];
  logic       i_ordy  [2];
  logic       i_flush [2];
  logic [7:0] i_dat   [2];
  logic       d_vld   [2];
  logic       d_rdy   [2];
  logic [7:0] d_dat   [2];
  logic [2:0] d_cnt   [2];

  powlib_epipe #(.W(8), .INIT(INIT), .S(S), .ESKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(i_dat[0]), .in_vld(i_vld[0]), .in_rdy(d_rdy[0]),
    .out_data(d_dat[0]), .out_vld(d_vld[0]), .out_rdy(i_ordy[0]), .flush(i_flush[0]),
    .cnt(d_cnt[0]));

  powlib_epipe #(.W(8), .INIT(INIT), .S(S), .ESKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(i_dat[1]), .in_vld(i_vld[1]), .in_rdy(d_rdy[1]),
    .out_data(d_dat[1]), .out_vld(d_vld[1]), .out_rdy(i_ordy[1]), .flush(i_flush[1]),
    .cnt(d_cnt[1]));

  // model: ordered word list (oldest first) with pipe position 0..S-1, plus skid list
  int         mpos [2][8];
  logic [7:0] mdat [2][8];
  int         mn   [2];
  logic [7:0] msk  [2][2];
  int         msn  [2];
  bit         mrdy [2];
  bit         macc [2];
  int         npos [8];

  int total = 0;
  int bad = 0;
  bit en_chk = 1'b0;
  int emits1 = 0;
  logic [7:0] got0 [$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // each word moves one place forward unless blocked by the word ahead of it
  task automatic adv(input int q, input bit ordy, output bit emit, output bit free0);
    int lim;
    int np;
    emit = 1'b0;
    lim = S;
    for (int k = 0; k < mn[q]; k++) begin
      if (k == 0 && mpos[q][0] == S - 1 && ordy) begin
        emit = 1'b1;
        npos[0] = S;
      end else begin
        np = mpos[q][k] + 1;
        if (np > lim - 1) np = lim - 1;
        npos[k] = np;
        lim = np;
      end
    end
    free0 = (lim > 0);
  endtask

  task automatic check_inst(input int q);
    bit e, f, ev, er;
    adv(q, i_ordy[q], e, f);
    ev = rst && !i_flush[q] && mn[q] > 0 && mpos[q][0] == S - 1;
    er = rst && !i_flush[q] && ((q == 0) ? f : mrdy[q]);
    chk($sformatf("out_vld%0d", q), int'(d_vld[q]), int'(ev));
    chk($sformatf("in_rdy%0d", q), int'(d_rdy[q]), int'(er));
    chk($sformatf("cnt%0d", q), int'(d_cnt[q]), mn[q] + msn[q]);
    chk($sformatf("cnt_max%0d", q), int'(d_cnt[q] <= ((q == 0) ? 3'd4 : 3'd6)), 1);
    if (ev) chk($sformatf("out_data%0d", q), int'(d_dat[q]), int'(mdat[q][0]));
    if (q == 0 && d_vld[0] && i_ordy[0]) got0.push_back(d_dat[0]);
    if (q == 1 && d_vld[1] && i_ordy[1]) emits1++;
  endtask

  task automatic commit(input int q);
    bit e, f, acc, er;
    int st;
    macc[q] = 1'b0;
    if (i_flush[q]) begin
      mn[q] = 0;
      msn[q] = 0;
      mrdy[q] = 1'b1;
    end else begin
      adv(q, i_ordy[q], e, f);
      er = (q == 0) ? f : mrdy[q];
      acc = i_vld[q] && er;
      st = e ? 1 : 0;
      for (int k = st; k < mn[q]; k++) begin
        mpos[q][k - st] = npos[k];
        mdat[q][k - st] = mdat[q][k];
      end
      mn[q] = mn[q] - st;
      if (q == 0) begin
        if (acc) begin
          mpos[q][mn[q]] = 0;
          mdat[q][mn[q]] = i_dat[q];
          mn[q]++;
        end
      end else begin
        if (f && msn[q] > 0) begin
          mpos[q][mn[q]] = 0;
          mdat[q][mn[q]] = msk[q][0];
          mn[q]++;
          msk[q][0] = msk[q][1];
          msn[q]--;
        end
        if (acc) begin
          msk[q][msn[q]] = i_dat[q];
          msn[q]++;
        end
        mrdy[q] = (msn[q] < 2);
      end
      macc[q] = acc;
    end
  endtask

  // compare process: DUT vs model every cycle, away from the active edge
  always @(negedge clk) begin
    if (en_chk) begin
      for (int q = 0; q < 2; q++) check_inst(q);
    end
  end

  // model state update at the edge, cleared asynchronously by reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < 2; q++) begin
        mn[q] = 0; msn[q] = 0; mrdy[q] = 1'b0; macc[q] = 1'b0;
      end
    end else begin
      for (int q = 0; q < 2; q++) commit(q);
    end
  end

  task automatic to_neg(); @(negedge clk); #1; endtask
  task automatic to_pos(); @(posedge clk); #1; endtask

  task automatic send0(input logic [7:0] v);
    int n;
    i_vld[0] = 1'b1;
    i_dat[0] = v;
    n = 0;
    do begin
      to_pos();
      n++;
    end while (!macc[0] && n < 12);
    chk("send_accepted", int'(macc[0]), 1);
    i_vld[0] = 1'b0;
  endtask

  task automatic drain0();
    i_vld[0] = 1'b0;
    i_ordy[0] = 1'b1;
    repeat (8) to_pos();
  endtask

  int val;
  int pv0, pr0, pv1, pr1;

  initial begin
    for (int q = 0; q < 2; q++) begin
      i_vld[q] = 1'b0; i_ordy[q] = 1'b1; i_flush[q] = 1'b0; i_dat[q] = 8'h00;
    end
    en_chk = 1'b1;
    to_neg();
    chk("rst_out_data", int'(d_dat[0]), 8'h5A);
    chk("rst_cnt", int'(d_cnt[0]), 0);
    repeat (2) to_pos();
    @(negedge clk); #2 rst = 1'b1;
    to_pos();

    // 1: streaming 1..8, out in cycles 4..11
    i_ordy[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      i_vld[0] = (c < 8);
      i_dat[0] = 8'(c + 1);
      to_neg();
      if (c >= 4) begin
        chk("t1_vld", int'(d_vld[0]), 1);
        chk("t1_data", int'(d_dat[0]), c - 3);
      end
      if (c >= 4 && c <= 8) chk("t1_cnt", int'(d_cnt[0]), 4);
      to_pos();
    end
    drain0();

    // 2: fill under backpressure, then release
    i_ordy[0] = 1'b0;
    val = 11;
    for (int c = 0; c < 7; c++) begin
      i_vld[0] = 1'b1;
      i_dat[0] = 8'(val);
      to_pos();
      if (macc[0]) val++;
    end
    i_vld[0] = 1'b0;
    to_neg();
    chk("t2_accepts", val, 15);
    chk("t2_cnt", int'(d_cnt[0]), 4);
    chk("t2_in_rdy", int'(d_rdy[0]), 0);
    to_pos();
    got0.delete();
    drain0();
    chk("t2_n", got0.size(), 4);
    for (int k = 0; k < 4 && k < got0.size(); k++) chk("t2_order", int'(got0[k]), 11 + k);

    // 3: bubble collapse
    i_ordy[0] = 1'b0;
    send0(8'hA1);
    repeat (6) to_pos();
    send0(8'hB2);
    send0(8'hC3);
    send0(8'hD4);
    to_neg();
    chk("t3_cnt", int'(d_cnt[0]), 4);
    chk("t3_in_rdy", int'(d_rdy[0]), 0);
    to_pos();
    got0.delete();
    drain0();
    chk("t3_n", got0.size(), 4);
    if (got0.size() == 4) begin
      chk("t3_a", int'(got0[0]), 8'hA1);
      chk("t3_b", int'(got0[1]), 8'hB2);
      chk("t3_c", int'(got0[2]), 8'hC3);
      chk("t3_d", int'(got0[3]), 8'hD4);
    end

    // 4: flush with 3 words held
    i_ordy[0] = 1'b0;
    send0(8'h31);
    send0(8'h32);
    send0(8'h33);
    i_flush[0] = 1'b1;
    i_vld[0] = 1'b1;
    i_dat[0] = 8'hEE;
    to_neg();
    chk("t4_flush_vld", int'(d_vld[0]), 0);
    chk("t4_flush_rdy", int'(d_rdy[0]), 0);
    to_pos();
    i_flush[0] = 1'b0;
    i_vld[0] = 1'b0;
    to_neg();
    chk("t4_vld", int'(d_vld[0]), 0);
    chk("t4_cnt", int'(d_cnt[0]), 0);
    chk("t4_data", int'(d_dat[0]), 8'h5A);
    to_pos();
    got0.delete();
    i_ordy[0] = 1'b1;
    send0(8'h41);
    send0(8'h42);
    drain0();
    chk("t4_n", got0.size(), 2);
    if (got0.size() == 2) begin
      chk("t4_w0", int'(got0[0]), 8'h41);
      chk("t4_w1", int'(got0[1]), 8'h42);
    end

    // 5: asynchronous reset mid-stream
    i_ordy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      i_vld[0] = 1'b1;
      i_dat[0] = 8'(8'h50 + c);
      to_pos();
    end
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("t5_vld", int'(d_vld[0]), 0);
    chk("t5_cnt", int'(d_cnt[0]), 0);
    chk("t5_rdy", int'(d_rdy[0]), 0);
    chk("t5_data", int'(d_dat[0]), 8'h5A);
    i_vld[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    got0.delete();
    repeat (8) to_pos();
    chk("t5_no_partial", got0.size(), 0);
    send0(8'h61);
    send0(8'h62);
    drain0();
    chk("t5_n", got0.size(), 2);
    if (got0.size() == 2) begin
      chk("t5_w0", int'(got0[0]), 8'h61);
      chk("t5_w1", int'(got0[1]), 8'h62);
    end

    // 6: random traffic on both instances
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        pv0 = $urandom_range(20, 100); pr0 = $urandom_range(10, 100);
        pv1 = $urandom_range(20, 100); pr1 = $urandom_range(10, 100);
      end
      i_vld[0]   = ($urandom_range(0, 99) < pv0);
      i_ordy[0]  = ($urandom_range(0, 99) < pr0);
      i_flush[0] = ($urandom_range(0, 199) == 0);
      i_dat[0]   = 8'($urandom);
      i_vld[1]   = ($urandom_range(0, 99) < pv1);
      i_ordy[1]  = ($urandom_range(0, 99) < pr1);
      i_flush[1] = ($urandom_range(0, 199) == 0);
      i_dat[1]   = 8'($urandom);
      to_pos();
    end
    chk("t6_emits", int'(emits1 > 1000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
